// File: rtl/pdp11_mem_arbiter.sv
// pdp11_mem_arbiter: shares the single-ported PDP-11 memory between the
// instruction-fetch stage and the execute-stage data access. The block turns
// byte addresses into word accesses with byte lanes, reports odd-address word
// accesses as bus errors and discards fetches cancelled by a taken branch.
// Arbitration happens only in IDLE, so after every ack there is one IDLE
// cycle in which both requesters' fresh requests are visible.
module pdp11_mem_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    localparam logic [2:0] LAT  = 3'(MEM_LATENCY);
    localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_ERR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  lat_q, lat_d;
    logic [3:0]  starve_q, starve_d;
    logic        cancel_q, cancel_d;   // in-flight fetch was flushed
    logic        own_q, own_d;         // 0 = fetch, 1 = data
    logic        byte_q, byte_d;
    logic        lo_q, lo_d;           // byte address bit 0 of the access
    logic        if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic        d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [15:0] d_rdata_q, d_rdata_d;
    logic        mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [1:0]  mem_be_q, mem_be_d;
    logic [14:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d, owner_q, owner_d;

    logic        fetch_ok, pick_data, g_byte;
    logic [15:0] g_addr, g_wdata;

    // State and registered outputs; everything clears on reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            starve_q    <= '0;
            cancel_q    <= 1'b0;
            own_q       <= 1'b0;
            byte_q      <= 1'b0;
            lo_q        <= 1'b0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            cancel_q    <= cancel_d;
            own_q       <= own_d;
            byte_q      <= byte_d;
            lo_q        <= lo_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            owner_q     <= owner_d;
        end
    end

    // Arbitration, sequencing and next values of every registered output
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        cancel_d    = cancel_q;
        own_d       = own_q;
        byte_d      = byte_q;
        lo_d        = lo_q;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = '0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fetch_ok    = if_req & ~flush;
        pick_data   = d_req & ~(fetch_ok & (starve_q == SLIM));
        g_addr      = pick_data ? d_addr : if_addr;
        g_byte      = pick_data & d_byte;
        g_wdata     = g_byte ? {d_wdata[7:0], d_wdata[7:0]} : d_wdata;

        case (state_q)
            S_IDLE: begin
                // Count data wins over a waiting fetch; anything else clears
                if (fetch_ok && pick_data)
                    starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
                else
                    starve_d = '0;
                if (fetch_ok || d_req) begin
                    own_d    = pick_data;
                    byte_d   = g_byte;
                    lo_d     = g_addr[0];
                    cancel_d = 1'b0;
                    if (g_addr[0] && !g_byte) begin
                        state_d  = S_ERR;
                        d_ack_d  = pick_data;
                        d_err_d  = pick_data;
                        if_ack_d = ~pick_data;
                        if_err_d = ~pick_data;
                    end else begin
                        state_d     = S_ACCESS;
                        lat_d       = '0;
                        mem_en_d    = 1'b1;
                        mem_we_d    = pick_data & d_we;
                        mem_be_d    = !g_byte ? 2'b11 : (g_addr[0] ? 2'b10 : 2'b01);
                        mem_addr_d  = g_addr[15:1];
                        mem_wdata_d = g_wdata;
                    end
                end
            end
            S_ACCESS: begin
                // A flush seen by the edge that loads if_ack still suppresses it
                if (!own_q && flush) cancel_d = 1'b1;
                if (lat_q == LAT) begin
                    state_d = S_RESP;
                    if (own_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = !byte_q ? mem_rdata :
                                    {8'h00, lo_q ? mem_rdata[15:8] : mem_rdata[7:0]};
                    end else begin
                        if_ack_d   = ~(cancel_q | flush);
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;   // RESP and ERR last one cycle
        endcase

        busy_d  = (state_d != S_IDLE);
        owner_d = (state_d != S_IDLE) & own_d;
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_pdp11_mem_arbiter.sv
// Randomized bench for pdp11_mem_arbiter. A transaction-level model decides
// grants from the arbitration rules, then books the expected outputs of each
// transaction into per-cycle expectation tables; the memory model returns a
// random word exactly MEM_LATENCY cycles after mem_en and noise otherwise.
module tb_pdp11_mem_arbiter;
    localparam int LAT  = 2;
    localparam int SLIM = 4;
    localparam int NCYC = 3000;
    localparam int N    = NCYC + 32;

    logic        clk = 1'b0;
    logic        reset_n, flush, if_req, d_req, d_we, d_byte;
    logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_ack, if_err, d_ack, d_err, mem_en, mem_we, busy, owner;
    logic [15:0] if_rdata, d_rdata, mem_wdata;
    logic [1:0]  mem_be;
    logic [14:0] mem_addr;

    always #5 clk = ~clk;

    pdp11_mem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Per-cycle expectations
    bit          e_busy[N], e_own[N], e_men[N], e_mwe[N], e_ifa[N], e_ife[N];
    bit          e_da[N], e_de[N], e_drchk[N], e_zero[N];
    logic [1:0]  e_mbe[N];
    logic [14:0] e_maddr[N];
    logic [15:0] e_mwd[N], e_ifr[N], e_dr[N];
    // Memory read data schedule
    bit          rd_v[N];
    logic [15:0] rd_w[N];

    // Model state
    int free_c = 0, starve = 0, fg_c = -1, fa_c = -1;
    // Requesters
    bit          f_act = 0, d_act = 0, d_w = 0, d_b = 0;
    logic [15:0] f_a = '0, d_a = '0, d_wd = '0;

    initial begin
        bit rst, fl, fe, de, pdat, bt, we;
        int pf, pdq, pfl, k, m;
        logic [15:0] addr, w;
        reset_n = 1'b0; flush = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0;
        for (int c = 0; c < NCYC; c++) begin
            cyc = c;
            @(posedge clk); #1;
            if (c > 0) begin
                chk("busy", busy, e_busy[c]);
                if (e_busy[c]) chk("owner", owner, e_own[c]);
                chk("mem_en", mem_en, e_men[c]);
                if (e_men[c]) begin
                    chk("mem_addr", mem_addr, e_maddr[c]);
                    chk("mem_be", mem_be, e_mbe[c]);
                    chk("mem_we", mem_we, e_mwe[c]);
                    if (e_mwe[c]) chk("mem_wdata", mem_wdata, e_mwd[c]);
                end
                chk("if_ack", if_ack, e_ifa[c]);
                chk("if_err", if_err, e_ife[c]);
                chk("d_ack", d_ack, e_da[c]);
                chk("d_err", d_err, e_de[c]);
                if (e_ifa[c]) chk("if_rdata", if_rdata, e_ifr[c]);
                if (e_da[c] && e_drchk[c]) chk("d_rdata", d_rdata, e_dr[c]);
                if (e_zero[c]) begin
                    chk("rst_data", {if_rdata, d_rdata, mem_wdata}, 64'd0);
                    chk("rst_ctl", {if_ack, if_err, d_ack, d_err, mem_en, mem_we,
                                    mem_be, mem_addr, busy, owner}, 64'd0);
                end
            end

            // Stimulus phases: light random, saturated contention, flush+reset
            if (c < 1000)      begin pf = 40;  pdq = 40;  pfl = 0; end
            else if (c < 1400) begin pf = 100; pdq = 100; pfl = 0; end
            else               begin pf = 50;  pdq = 50;  pfl = 8; end
            rst = (c < 3) || (c > 1400 && (c % 197) == 0);

            // Requesters drop req the cycle after ack (or after flush)
            if (c > 0 && (e_ifa[c-1] || e_ife[c-1] || flush)) f_act = 0;
            if (c > 0 && (e_da[c-1] || e_de[c-1])) d_act = 0;
            if (rst) begin
                f_act = 0; d_act = 0;
            end else begin
                if (!f_act && int'($urandom_range(99)) < pf) begin
                    f_act = 1;
                    f_a = 16'($urandom);
                    f_a[0] = ($urandom_range(99) < 15);
                end
                if (!d_act && int'($urandom_range(99)) < pdq) begin
                    d_act = 1;
                    d_a = 16'($urandom);
                    d_a[0] = ($urandom_range(99) < 30);
                    d_w = $urandom_range(1);
                    d_b = $urandom_range(1);
                    d_wd = 16'($urandom);
                end
            end
            fl = !rst && (int'($urandom_range(99)) < pfl) && !e_ifa[c];

            reset_n = !rst; flush = fl;
            if_req = f_act; if_addr = f_a;
            d_req = d_act; d_addr = d_a; d_we = d_w; d_byte = d_b; d_wdata = d_wd;
            mem_rdata = rd_v[c] ? rd_w[c] : 16'($urandom);

            // Model of the edge ending cycle c
            if (rst) begin
                for (int j = c + 1; j <= c + LAT + 4; j++) begin
                    e_busy[j] = 0; e_own[j] = 0; e_men[j] = 0; e_ifa[j] = 0;
                    e_ife[j] = 0; e_da[j] = 0; e_de[j] = 0; e_drchk[j] = 0;
                end
                e_zero[c+1] = 1;
                free_c = c + 1; starve = 0; fa_c = -1;
            end else begin
                if (fl && fg_c < c && c < fa_c) e_ifa[fa_c] = 0;
                if (c >= free_c) begin
                    fe = f_act && !fl;
                    de = d_act;
                    pdat = de && !(fe && starve == SLIM);
                    if (fe && pdat) starve = (starve < 15) ? starve + 1 : 15;
                    else            starve = 0;
                    if (fe || de) begin
                        addr = pdat ? d_a : f_a;
                        bt = pdat && d_b;
                        we = pdat && d_w;
                        if (addr[0] && !bt) begin
                            k = c + 1;
                            e_busy[k] = 1; e_own[k] = pdat;
                            if (pdat) begin
                                e_da[k] = 1; e_de[k] = 1; e_dr[k] = '0; e_drchk[k] = 1;
                            end else begin
                                e_ifa[k] = 1; e_ife[k] = 1; e_ifr[k] = '0;
                            end
                            free_c = c + 2;
                        end else begin
                            for (int j = c + 1; j <= c + LAT + 2; j++) begin
                                e_busy[j] = 1; e_own[j] = pdat;
                            end
                            e_men[c+1]   = 1;
                            e_maddr[c+1] = addr[15:1];
                            e_mbe[c+1]   = !bt ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
                            e_mwe[c+1]   = we;
                            e_mwd[c+1]   = bt ? {d_wd[7:0], d_wd[7:0]} : d_wd;
                            m = c + 1 + LAT;
                            w = 16'($urandom);
                            rd_v[m] = 1; rd_w[m] = w;
                            k = c + LAT + 2;
                            if (pdat) begin
                                e_da[k] = 1; e_drchk[k] = !we;
                                e_dr[k] = !bt ? w : {8'h00, addr[0] ? w[15:8] : w[7:0]};
                            end else begin
                                e_ifa[k] = 1; e_ifr[k] = w;
                                fg_c = c; fa_c = k;
                            end
                            free_c = c + LAT + 3;
                        end
                    end
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
